// File: rtl/stage_writeback.sv
`default_nettype none
// ============================================================================
// Module      : stage_writeback
// Description : Final pipeline stage. Aligns and extends load data, selects
//               load or ALU result, drives the registered register-file write
//               port, exposes forwarding taps, counts retired instructions and
//               traps misaligned loads.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_writeback #(
  parameter int          INSTRET_WIDTH      = 64,
  parameter bit          TRAP_ON_MISALIGNED = 1'b1,
  parameter logic [31:0] NOP_PC             = 32'hFFFF_FFFF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              dmem_read_data_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              ir_i,
  input  logic                     load_i,
  input  logic [1:0]               ma_size_i,
  input  logic [1:0]               ma_alignment_i,
  input  logic [4:0]               wb_addr_i,
  input  logic [31:0]              wb_data_i,
  input  logic                     wb_ready_i,
  input  logic                     wb_valid_i,
  output logic                     empty_async_o,
  output logic [4:0]               fwd_addr_async_o,
  output logic [31:0]              fwd_data_async_o,
  output logic                     fwd_valid_async_o,
  output logic [4:0]               rf_write_addr_o,
  output logic [31:0]              rf_write_data_o,
  output logic                     rf_write_enable_o,
  output logic                     retired_o,
  output logic [INSTRET_WIDTH-1:0] instret_o,
  output logic                     misaligned_o,
  output logic [31:0]              misaligned_pc_o
);

  // Access size encoding shared with the memory-access stage.
  localparam logic [1:0] MA_SIZE_B = 2'd0;
  localparam logic [1:0] MA_SIZE_H = 2'd1;
  localparam logic [1:0] MA_SIZE_W = 2'd2;

  logic [31:0] shifted;
  logic [31:0] extended;
  logic [31:0] resolved;
  logic        unsigned_ld;
  logic        misalign;
  logic        trap;
  logic        bubble;
  logic        commit;
  logic        retire;

  logic [4:0]               rf_addr_q,    rf_addr_d;
  logic [31:0]              rf_data_q,    rf_data_d;
  logic                     rf_en_q,      rf_en_d;
  logic                     retired_q,    retired_d;
  logic [INSTRET_WIDTH-1:0] instret_q,    instret_d;
  logic                     mis_q,        mis_d;
  logic [31:0]              mis_pc_q,     mis_pc_d;

  // Only the unsigned-load bit of the instruction matters here; the ready
  // flag is informational because loads are resolved in this stage anyway.
  logic unused_ok;
  assign unused_ok = ^{ir_i[31:15], ir_i[13:0], wb_ready_i};

  // Load alignment/extension, result selection and commit qualification.
  always_comb begin
    unsigned_ld = ir_i[14];
    shifted     = dmem_read_data_i >> {ma_alignment_i, 3'b000};
    case (ma_size_i)
      MA_SIZE_B: extended = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
      MA_SIZE_H: extended = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
      default:   extended = shifted;
    endcase
    resolved = load_i ? extended : wb_data_i;
    misalign = load_i &
               (((ma_size_i == MA_SIZE_H) & ma_alignment_i[0]) |
                ((ma_size_i == MA_SIZE_W) & (ma_alignment_i != 2'd0)));
    trap     = misalign & TRAP_ON_MISALIGNED;
    bubble   = (pc_i == NOP_PC);
    commit   = ~bubble & wb_valid_i & (wb_addr_i != 5'd0) & ~trap;
    retire   = ~bubble & ~trap;
  end

  // Next-state values for the write port, retire counter and trap record.
  always_comb begin
    rf_addr_d = wb_addr_i;
    rf_data_d = resolved;
    rf_en_d   = commit;
    retired_d = retire;
    instret_d = retire ? instret_q + INSTRET_WIDTH'(1) : instret_q;
    mis_d     = trap;
    mis_pc_d  = trap ? pc_i : mis_pc_q;
  end

  // State registers; reset drops any in-flight commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_addr_q <= 5'd0;
      rf_data_q <= 32'd0;
      rf_en_q   <= 1'b0;
      retired_q <= 1'b0;
      instret_q <= '0;
      mis_q     <= 1'b0;
      mis_pc_q  <= 32'd0;
    end else begin
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      rf_en_q   <= rf_en_d;
      retired_q <= retired_d;
      instret_q <= instret_d;
      mis_q     <= mis_d;
      mis_pc_q  <= mis_pc_d;
    end
  end

  assign empty_async_o     = bubble;
  assign fwd_addr_async_o  = wb_addr_i;
  assign fwd_data_async_o  = resolved;
  assign fwd_valid_async_o = commit;
  assign rf_write_addr_o   = rf_addr_q;
  assign rf_write_data_o   = rf_data_q;
  assign rf_write_enable_o = rf_en_q;
  assign retired_o         = retired_q;
  assign instret_o         = instret_q;
  assign misaligned_o      = mis_q;
  assign misaligned_pc_o   = mis_pc_q;

endmodule
`default_nettype wire
